// File: rtl/tdm_1_n_demux.sv
// Serial TDM 1:N demultiplexer: one bit per valid beat, slot-0 sync, full frame out as N-bit word.
// Latency: the slot N-1 beat's edge updates out and pulses out_valid, so both are visible the next cycle.
// Backpressure: none; din_valid low freezes all state, and misaligned sync drops the frame and resyncs.
module tdm_1_n_demux #(
  parameter int N     = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [N-1:0]     out,
  output logic             out_valid,
  output logic [SEL_W-1:0] sel,
  output logic             locked,
  output logic             sync_err
);

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  // Last slot index; sel wraps from here to 0 explicitly so non-power-of-two N works.
  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N - 1);

  logic [0:0]   state;
  logic [N-1:0] shadow;
  logic [N-1:0] frame_word;

  // Completed frame: the shadow with the final slot taken straight from the current beat.
  always_comb begin
    frame_word        = shadow;
    frame_word[N-1]   = din;
  end

  // Slot tracking, alignment FSM, shadow capture and frame delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      sel       <= '0;
      shadow    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      if (din_valid) begin
        if (state == HUNT) begin
          // Only a sync-marked beat can start alignment; everything else is dropped.
          if (frame_sync) begin
            shadow[0] <= din;
            sel       <= SEL_W'(1);
            state     <= LOCKED;
          end
        end else if (frame_sync) begin
          // Sync always starts a new frame; if it arrives mid-frame the partial frame is lost.
          shadow[0] <= din;
          sel       <= SEL_W'(1);
          if (sel != '0) begin
            sync_err <= 1'b1;
          end
        end else if (sel == '0) begin
          // Expected a sync marker on slot 0 and did not get one: alignment lost.
          sync_err <= 1'b1;
          state    <= HUNT;
        end else if (sel == LAST_SLOT) begin
          out       <= frame_word;
          out_valid <= 1'b1;
          sel       <= '0;
        end else begin
          shadow[sel] <= din;
          sel         <= sel + SEL_W'(1);
        end
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_1_n_demux.sv
// Bench for tdm_1_n_demux: table of frames plus hand-written reset / early-sync / missing-sync sequences.
// Expected frames are pushed to a scoreboard when driven and popped when out_valid is seen.
// Inputs change 1 time unit after the rising edge; outputs are sampled then or on the falling edge.
module tb_tdm_1_n_demux;

  localparam int N     = 16;
  localparam int SEL_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             din;
  logic             din_valid;
  logic             frame_sync;
  logic [N-1:0]     out_w;
  logic             out_valid;
  logic [SEL_W-1:0] sel;
  logic             locked;
  logic             sync_err;

  tdm_1_n_demux #(.N(N), .SEL_W(SEL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .out        (out_w),
    .out_valid  (out_valid),
    .sel        (sel),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] data;
    bit           gapped;
    logic [N-1:0] exp_out;
  } vec_t;

  vec_t         tbl [6];
  logic [N-1:0] sb [$];
  int           vcyc [$];
  int           cyc = 0;
  int           serr_cnt = 0;
  int           checks = 0;
  int           passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      passes++;
  endtask

  // Scoreboard side: every out_valid must match the oldest pushed frame.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        vcyc.push_back(cyc);
        if (sb.size() == 0) check("unexpected_valid", 32'(out_valid), 32'd0);
        else                check("sb_out", 32'(out_w), 32'(sb.pop_front()));
      end
      if (sync_err) begin
        serr_cnt++;
        check("serr_with_valid", 32'(out_valid), 32'd0);
      end
    end
  end

  task automatic beat(input logic d, input logic fs);
    din        = d;
    frame_sync = fs;
    din_valid  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    din_valid  = 1'b0;
    din        = 1'($urandom);
    frame_sync = 1'($urandom);
    @(posedge clk);
    #1;
  endtask

  // One full frame, slot k carried on beat k, sync on beat 0.
  task automatic send_frame(input logic [N-1:0] data, input bit gapped,
                            input logic [N-1:0] exp_out, input logic exp_serr0);
    sb.push_back(exp_out);
    for (int k = 0; k < N; k++) begin
      beat(data[k], k == 0);
      check("sel_step", 32'(sel), 32'((k + 1) % N));
      if (k == 0) begin
        check("locked_after_sync", 32'(locked), 32'd1);
        check("serr_slot0", 32'(sync_err), 32'(exp_serr0));
      end
      if (gapped && k < N - 1) begin
        idle();
        check("sel_hold_gap", 32'(sel), 32'((k + 1) % N));
      end
    end
    check("valid_latency", 32'(out_valid), 32'd1);
    check("out_word", 32'(out_w), 32'(exp_out));
  endtask

  initial begin
    tbl[0] = '{16'hA5C3, 1'b0, 16'hA5C3};
    tbl[1] = '{16'hA5C3, 1'b1, 16'hA5C3};
    tbl[2] = '{16'h8001, 1'b0, 16'h8001};
    tbl[3] = '{16'h7FFE, 1'b0, 16'h7FFE};
    tbl[4] = '{16'hFFFF, 1'b1, 16'hFFFF};
    tbl[5] = '{16'h1234, 1'b0, 16'h1234};

    rst_n = 1'b1; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out", 32'(out_w), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(); idle();

    // Table frames run contiguously: entries 2 and 3 are back-to-back.
    for (int i = 0; i < 6; i++)
      send_frame(tbl[i].data, tbl[i].gapped, tbl[i].exp_out, 1'b0);
    idle();
    check("table_no_serr", 32'(serr_cnt), 32'd0);
    check("table_sb_empty", 32'(sb.size()), 32'd0);
    check("b2b_spacing", 32'(vcyc[3] - vcyc[2]), 32'd16);
    check("gapped_spacing", 32'(vcyc[1] - vcyc[0]), 32'd31);

    // Asynchronous reset in the middle of a frame.
    beat(1'b1, 1'b1);
    for (int k = 1; k < 7; k++) beat(1'($urandom), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(out_w), 32'd0);
    check("midrst_locked", 32'(locked), 32'd0);
    check("midrst_sel", 32'(sel), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sync_err", 32'(sync_err), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) beat(1'($urandom), 1'b0);
    check("postrst_locked", 32'(locked), 32'd0);
    check("postrst_sel", 32'(sel), 32'd0);
    send_frame(16'h3C3C, 1'b0, 16'h3C3C, 1'b0);

    // Early sync on slot 5, then a full 00FF frame.
    beat(1'b1, 1'b1);
    for (int k = 1; k < 5; k++) beat(1'b0, 1'b0);
    send_frame(16'h00FF, 1'b0, 16'h00FF, 1'b1);
    idle();
    check("early_serr_count", 32'(serr_cnt), 32'd1);

    // Missing sync on the slot-0 beat after a good frame.
    send_frame(16'h5A5A, 1'b0, 16'h5A5A, 1'b0);
    beat(1'b1, 1'b0);
    check("miss_serr", 32'(sync_err), 32'd1);
    check("miss_locked", 32'(locked), 32'd0);
    check("miss_sel", 32'(sel), 32'd0);
    for (int k = 0; k < 5; k++) beat(1'($urandom), 1'b0);
    check("hunt_locked", 32'(locked), 32'd0);
    check("hunt_sel", 32'(sel), 32'd0);
    send_frame(16'hC33C, 1'b0, 16'hC33C, 1'b0);

    idle(); idle(); idle();
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    check("final_serr_count", 32'(serr_cnt), 32'd2);
    check("final_valid_count", 32'(vcyc.size()), 32'd10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tdm_1_n_demux.md
# tdm_1_n_demux

Serial time-division 1:N demultiplexer: receives one data bit per valid beat from an N-slot TDM stream and delivers each complete frame as an N-bit parallel word. It is the receiving end of the N:1 multiplexor datapath. The mux serialises channels by stepping its select; this block tracks the same slot index, stores each bit into its channel position, and presents the full word with a one-cycle valid strobe. Frame alignment comes from a slot-0 sync marker. The block detects loss of alignment and resynchronises.

## Interface
- `N`, default 16: number of channels/slots per frame; N >= 2, need not be a power of two.
- `SEL_W`, default 4: slot index width; must be >= ceil(log2(N)).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  1  serial data bit for the current slot.
- `din_valid`  in  1  beat qualifier; `din`/`frame_sync` are sampled only when high.
- `frame_sync`  in  1  marks the beat carrying slot 0.
- `out`  out  N  last completed frame; slot k lands in `out[k]`.
- `out_valid`  out  1  one-cycle strobe when `out` is updated.
- `sel`  out  SEL_W  slot index expected on the next valid beat.
- `locked`  out  1  high while frame-aligned.
- `sync_err`  out  1  one-cycle strobe on an alignment violation.

## Operation
- Reset values (asynchronous, immediate on `rst_n` low):
  - `out` = 0, `out_valid` = 0, `sync_err` = 0, `locked` = 0.
  - `sel` = 0, shadow register = 0, state = HUNT.
- States: HUNT, LOCKED. `locked` = (state == LOCKED), registered.
- HUNT:
  - Beats without `frame_sync` are discarded; `sel` stays 0.
  - A beat with `frame_sync` stores `din` in `shadow[0]`, sets `sel` to 1, and moves to LOCKED.
- LOCKED, beat with `sel` = k, 0 < k < N-1, `frame_sync` = 0: `shadow[k]` <= `din`; `sel` <= k+1.
- LOCKED, beat with `sel` = N-1, `frame_sync` = 0 (frame complete):
  - `out` <= shadow with bit N-1 replaced by `din`.
  - `out_valid` <= 1; `sel` <= 0 (wrap).
- LOCKED, beat with `sel` = 0:
  - If `frame_sync` = 1: store `shadow[0]`, `sel` <= 1.
  - If `frame_sync` = 0 (missing sync): `sync_err` <= 1, state <= HUNT, beat discarded, `sel` stays 0.
- LOCKED, beat with `frame_sync` = 1 while `sel` != 0 (early sync):
  - `sync_err` <= 1 and the partial frame is dropped (no `out_valid`).
  - The beat is taken as slot 0 of a new frame: `shadow[0]` <= `din`, `sel` <= 1, state stays LOCKED.
- `din_valid` low: all state, `sel` and shadow hold. `out_valid` and `sync_err` are 0 on every cycle without a qualifying event.
- `out` holds its value between frames; the shadow is never visible on `out` before a frame completes.
- Slot arithmetic: `sel` increments by 1 and wraps from N-1 to 0 explicitly, never by natural overflow, so non-power-of-two N is correct.

## Timing
- Latency: the edge that samples the slot N-1 beat also updates `out` and raises `out_valid`. Both are visible in the following cycle, for exactly one cycle.
- Throughput: one bit per clock; a new frame's `frame_sync` beat may directly follow the slot N-1 beat, with no idle cycle required.
- `sync_err` is asserted for one cycle, in the cycle after the offending beat. It never coincides with `out_valid` for the same beat.
- An asynchronous reset mid-frame discards the partial frame. The first post-reset frame requires a fresh `frame_sync`.
- `sel` is registered and changes only on accepted beats.

## Test plan
- **Reset:** drive random `din`/`frame_sync` and pulse `rst_n` low mid-frame -> all outputs 0 immediately, `locked` = 0; the next frame without `frame_sync` produces no `out_valid`.
- **Single frame:** send 16'hA5C3 LSB-slot-first on 16 contiguous beats, `frame_sync` on beat 0 -> `locked` = 1 after beat 0; `out` = 16'hA5C3 with a single `out_valid` pulse one cycle after beat 15; `sel` returns to 0.
- **Gapped beats:** same frame with `din_valid` low every other cycle -> identical `out`; `sel` holds during gaps; `out_valid` after the 16th valid beat only.
- **Back-to-back frames:** send 16'h8001 then 16'h7FFE with no gap -> two `out_valid` pulses exactly 16 cycles apart, carrying 16'h8001 then 16'h7FFE; `sync_err` stays 0.
- **Early sync:** assert `frame_sync` on slot 5, then send 16 beats of 16'h00FF -> `sync_err` pulse, no `out_valid` for the broken frame, `locked` stays 1, then `out` = 16'h00FF.
- **Missing sync:** complete a frame, then send the next slot-0 beat without `frame_sync` -> `sync_err` pulse, `locked` = 0, following beats ignored until the next `frame_sync`, which restarts at slot 0.
